// File: rtl/qmult_seq.sv
// Sequential sign-magnitude fixed-point multiplier. It shares its number format and
// start/complete handshake with the iterative divider and consumes one multiplier bit per clock.
module qmult_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    input  logic         start,
    output logic [N-1:0] product_out,
    output logic         overflow,
    output logic         complete
);

    localparam int AW = 2 * (N - 1);
    localparam int CW = $clog2(N);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] r_mcand;
    logic [N-2:0]  r_mplier;
    logic          r_sign;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_product;
    logic          r_overflow;

    logic [AW-1:0] w_accNext;
    logic          w_ovf;
    logic [N-2:0]  w_mag;
    logic [Q-1:0]  w_unusedFraction;

    // The final add is folded into result formation, so the completion edge sees the full sum.
    always_comb begin
        w_accNext        = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_ovf            = |w_accNext[AW-1:N-1+Q];
        w_mag            = w_ovf ? '1 : w_accNext[N-2+Q:Q];
        w_unusedFraction = w_accNext[Q-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_sign     <= 1'b0;
            r_count    <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{(N-1){1'b0}}, multiplicand[N-2:0]};
                        r_mplier <= multiplier[N-2:0];
                        r_sign   <= multiplicand[N-1] ^ multiplier[N-1];
                        r_acc    <= '0;
                        r_count  <= CW'(N - 2);
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (r_count == '0) begin
                        // A zero magnitude never carries a sign bit.
                        r_product  <= {r_sign & (|w_mag), w_mag};
                        r_overflow <= w_ovf;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign product_out = r_product;
    assign overflow    = r_overflow;
    assign complete    = (r_state == S_IDLE);

endmodule

// File: tb/tb_qmult_seq.sv
// Directed testbench for qmult_seq: each task drives one scenario and checks it against
// hand-computed Q15 products.
module tb_qmult_seq;

    logic        clk;
    logic        rst;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        start;
    logic [31:0] product_out;
    logic        overflow;
    logic        complete;

    int nCompared;
    int nMismatched;

    qmult_seq #(.Q(15), .N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .start        (start),
        .product_out  (product_out),
        .overflow     (overflow),
        .complete     (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one operation, then count edges until complete rises again (bounded).
    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output logic o, output int lat);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (complete !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = product_out;
        o = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        nCompared++;
        if (complete !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_complete: got %b want 1", complete);
        end
        nCompared++;
        if (product_out !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_product: got %h want 00000000", product_out);
        end
        nCompared++;
        if (overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_basic();
        logic [31:0] p;
        logic o;
        int lat;
        runOp(32'h0000C000, 32'h00010000, p, o, lat);
        nCompared++;
        if (lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL basic_latency: got %0d want 31", lat);
        end
        nCompared++;
        if (p !== 32'h00018000) begin
            nMismatched++;
            $display("[TB] FAIL basic_product: got %h want 00018000", p);
        end
        nCompared++;
        if (o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL basic_overflow: got %b want 0", o);
        end
    endtask

    task automatic test_sign();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vp [3];
        logic [31:0] p;
        logic o;
        int lat;
        va[0] = 32'h8000C000; vb[0] = 32'h00010000; vp[0] = 32'h80018000;
        va[1] = 32'h8000C000; vb[1] = 32'h80010000; vp[1] = 32'h00018000;
        va[2] = 32'h80000000; vb[2] = 32'h00008000; vp[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            runOp(va[i], vb[i], p, o, lat);
            nCompared++;
            if (p !== vp[i] || lat !== 31) begin
                nMismatched++;
                $display("[TB] FAIL sign_%0d: got %h lat %0d want %h lat 31", i, p, lat, vp[i]);
            end
            nCompared++;
            if (o !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL sign_ovf_%0d: got %b want 0", i, o);
            end
        end
    endtask

    task automatic test_fraction();
        logic [31:0] p;
        logic o;
        int lat;
        runOp(32'h00004000, 32'h00004000, p, o, lat);
        nCompared++;
        if (p !== 32'h00002000 || o !== 1'b0 || lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL half_squared: got %h ovf %b lat %0d want 00002000 ovf 0 lat 31", p, o, lat);
        end
        runOp(32'h00000001, 32'h00004000, p, o, lat);
        nCompared++;
        if (p !== 32'h00000000 || o !== 1'b0 || lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL truncate: got %h ovf %b lat %0d want 00000000 ovf 0 lat 31", p, o, lat);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] p;
        logic o;
        int lat;
        runOp(32'h7FFFFFFF, 32'h00010000, p, o, lat);
        nCompared++;
        if (p !== 32'h7FFFFFFF) begin
            nMismatched++;
            $display("[TB] FAIL sat_product: got %h want 7fffffff", p);
        end
        nCompared++;
        if (o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sat_overflow: got %b want 1", o);
        end
        runOp(32'h00008000, 32'h00008000, p, o, lat);
        nCompared++;
        if (p !== 32'h00008000 || lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL after_sat_product: got %h lat %0d want 00008000 lat 31", p, lat);
        end
        nCompared++;
        if (o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL after_sat_overflow: got %b want 0", o);
        end
    endtask

    // Previous result is 0x00008000; it must survive the whole busy window.
    task automatic test_busy_ignore();
        int lat;
        int changed;
        @(negedge clk);
        multiplicand = 32'h00004000;
        multiplier   = 32'h00004000;
        start        = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        changed = 0;
        while (complete !== 1'b1 && lat < 100) begin
            start        = ~start;
            multiplicand = 32'h7FFFFFFF ^ lat;
            multiplier   = 32'h00010000 + lat;
            if (product_out !== 32'h00008000 || overflow !== 1'b0) changed++;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        nCompared++;
        if (changed !== 0) begin
            nMismatched++;
            $display("[TB] FAIL busy_hold: got %0d early changes want 0", changed);
        end
        nCompared++;
        if (product_out !== 32'h00002000 || lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL busy_result: got %h lat %0d want 00002000 lat 31", product_out, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        multiplicand = 32'h0000C000;
        multiplier   = 32'h00010000;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 32'h00004000;
        multiplier   = 32'h00004000;
        lat = 0;
        while (complete !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nCompared++;
        if (product_out !== 32'h00018000 || lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL b2b_first: got %h lat %0d want 00018000 lat 31", product_out, lat);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        nCompared++;
        if (complete !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_accept: got complete %b want 0", complete);
        end
        lat = 1;
        while (complete !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nCompared++;
        if (product_out !== 32'h00002000 || lat !== 32) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second: got %h lat %0d want 00002000 lat 32", product_out, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p;
        logic o;
        int lat;
        @(negedge clk);
        multiplicand = 32'h7FFFFFFF;
        multiplier   = 32'h00010000;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        nCompared++;
        if (complete !== 1'b1 || product_out !== 32'h0 || overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset: got complete %b product %h ovf %b want 1 00000000 0",
                     complete, product_out, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        runOp(32'h0000C000, 32'h00010000, p, o, lat);
        nCompared++;
        if (p !== 32'h00018000 || o !== 1'b0 || lat !== 31) begin
            nMismatched++;
            $display("[TB] FAIL after_reset: got %h ovf %b lat %0d want 00018000 ovf 0 lat 31", p, o, lat);
        end
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_basic();
        test_sign();
        test_fraction();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
